// File: rtl/counter_updown_mod.sv
// Modulo-N up/down counter with parallel load, 161-style TC cascade,
// registered wrap pulse and a sticky out-of-range load flag.
module counter_updown_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             LD_n,
  input  logic [WIDTH-1:0] D,
  input  logic             EP,
  input  logic             ET,
  input  logic             UD,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP,
  output logic             ERR
);

  // Load-range compare is done one bit wider so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic at_max, at_zero, d_bad, cnt_en;

  assign at_max  = (Q == MAX);
  assign at_zero = (Q == '0);
  assign d_bad   = ({1'b0, D} >= MOD_EXT);
  assign cnt_en  = EP & ET;

  // TC ignores EP so a paused low stage still enables the next stage correctly.
  assign TC = ET & (UD ? at_max : at_zero);

  always_ff @(posedge CP) begin
    if (CR) begin
      Q    <= '0;
      WRAP <= 1'b0;
      ERR  <= 1'b0;
    end else if (!LD_n) begin
      Q    <= d_bad ? MAX : D;
      WRAP <= 1'b0;
      if (d_bad) ERR <= 1'b1;
    end else if (cnt_en) begin
      if (UD) begin
        Q    <= at_max ? '0 : Q + ONE;
        WRAP <= at_max;
      end else begin
        Q    <= at_zero ? MAX : Q - ONE;
        WRAP <= at_zero;
      end
    end else begin
      WRAP <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: mod-10 unit, a mod-10 cascade pair
// and a mod-16 build sharing one clock.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       cr, ld_n, ep, et, ud;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, wrap, err;

  logic       c_cr;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;

  logic       m_cr, m_ld_n, m_en;
  logic [3:0] m_d, m_q;
  logic       m_tc, m_wrap, m_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) dut (
    .CP(clk), .CR(cr), .LD_n(ld_n), .D(d), .EP(ep), .ET(et), .UD(ud),
    .Q(q), .TC(tc), .WRAP(wrap), .ERR(err));

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) u_lo (
    .CP(clk), .CR(c_cr), .LD_n(1'b1), .D(4'd0), .EP(1'b1), .ET(1'b1), .UD(1'b1),
    .Q(lo_q), .TC(lo_tc), .WRAP(lo_wrap), .ERR(lo_err));

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) u_hi (
    .CP(clk), .CR(c_cr), .LD_n(1'b1), .D(4'd0), .EP(1'b1), .ET(lo_tc), .UD(1'b1),
    .Q(hi_q), .TC(hi_tc), .WRAP(hi_wrap), .ERR(hi_err));

  counter_updown_mod #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .CP(clk), .CR(m_cr), .LD_n(m_ld_n), .D(m_d), .EP(m_en), .ET(m_en), .UD(1'b1),
    .Q(m_q), .TC(m_tc), .WRAP(m_wrap), .ERR(m_err));

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cr = 1; ld_n = 0; ep = 1; et = 1; ud = 1; d = 4'd5;
    tick();
    tests++; if (q !== 4'd0) begin fails++; $display("FAIL reset_q: got %0d exp 0", q); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %b exp 0", wrap); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b exp 0", err); end
    cr = 0; ld_n = 1;
    repeat (7) tick();
    tests++; if (q !== 4'd7) begin fails++; $display("FAIL reset_pre_q: got %0d exp 7", q); end
    cr = 1;
    tick();
    tests++; if (q !== 4'd0) begin fails++; $display("FAIL reset_mid_q: got %0d exp 0", q); end
    cr = 0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_q;
    ld_n = 1; ep = 1; et = 1; ud = 1;
    tests++; if (tc !== 1'b0) begin fails++; $display("FAIL up_tc0: got %b exp 0", tc); end
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_q = 4'((i + 1) % 10);
      tests++; if (q !== exp_q) begin fails++; $display("FAIL up_q[%0d]: got %0d exp %0d", i, q, exp_q); end
      tests++; if (tc !== (exp_q == 4'd9)) begin fails++; $display("FAIL up_tc[%0d]: got %b exp %b", i, tc, exp_q == 4'd9); end
      tests++; if (wrap !== (i == 9)) begin fails++; $display("FAIL up_wrap[%0d]: got %b exp %b", i, wrap, i == 9); end
    end
  endtask

  task automatic test_down_wrap();
    ld_n = 0; d = 4'd1;
    tick();
    tests++; if (q !== 4'd1) begin fails++; $display("FAIL dn_load: got %0d exp 1", q); end
    ld_n = 1; ud = 0;
    tick();
    tests++; if (q !== 4'd0) begin fails++; $display("FAIL dn_q0: got %0d exp 0", q); end
    tests++; if (tc !== 1'b1) begin fails++; $display("FAIL dn_tc0: got %b exp 1", tc); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL dn_wrap0: got %b exp 0", wrap); end
    ud = 1; #1;
    tests++; if (tc !== 1'b0) begin fails++; $display("FAIL dn_tc_ud: got %b exp 0", tc); end
    ud = 0; #1;
    tests++; if (tc !== 1'b1) begin fails++; $display("FAIL dn_tc_ud_back: got %b exp 1", tc); end
    tick();
    tests++; if (q !== 4'd9) begin fails++; $display("FAIL dn_q9: got %0d exp 9", q); end
    tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL dn_wrap9: got %b exp 1", wrap); end
    tests++; if (tc !== 1'b0) begin fails++; $display("FAIL dn_tc9: got %b exp 0", tc); end
    tick();
    tests++; if (q !== 4'd8) begin fails++; $display("FAIL dn_q8: got %0d exp 8", q); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL dn_wrap8: got %b exp 0", wrap); end
    ld_n = 0; d = 4'd5;
    tick();
    ld_n = 1; ud = 1;
    tick();
    tests++; if (q !== 4'd6) begin fails++; $display("FAIL dn_flip: got %0d exp 6", q); end
  endtask

  task automatic test_load_range();
    ld_n = 0; ep = 1; et = 1; ud = 1; d = 4'd6;
    tick();
    tests++; if (q !== 4'd6) begin fails++; $display("FAIL ld6_q: got %0d exp 6", q); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL ld6_err: got %b exp 0", err); end
    d = 4'd12;
    tick();
    tests++; if (q !== 4'd9) begin fails++; $display("FAIL ld12_q: got %0d exp 9", q); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL ld12_err: got %b exp 1", err); end
    d = 4'd3;
    tick();
    tests++; if (q !== 4'd3) begin fails++; $display("FAIL ld3_q: got %0d exp 3", q); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL ld3_err: got %b exp 1", err); end
    ld_n = 1;
    repeat (2) tick();
    tests++; if (q !== 4'd5 || err !== 1'b1) begin fails++; $display("FAIL cnt_err: got q=%0d err=%b exp q=5 err=1", q, err); end
    cr = 1;
    tick();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL cr_err: got %b exp 0", err); end
    cr = 0; ld_n = 0; d = 4'd10;
    tick();
    tests++; if (q !== 4'd9 || err !== 1'b1) begin fails++; $display("FAIL ld10: got q=%0d err=%b exp q=9 err=1", q, err); end
    cr = 1; ld_n = 1;
    tick();
    cr = 0; ld_n = 0; d = 4'd9;
    tick();
    tests++; if (q !== 4'd9 || err !== 1'b0) begin fails++; $display("FAIL ld9: got q=%0d err=%b exp q=9 err=0", q, err); end
    ld_n = 1;
  endtask

  task automatic test_enables();
    ld_n = 0; d = 4'd9; ep = 0; et = 1; ud = 1;
    tick();
    ld_n = 1;
    tick();
    tests++; if (q !== 4'd9) begin fails++; $display("FAIL en_hold_ep: got %0d exp 9", q); end
    tests++; if (tc !== 1'b1) begin fails++; $display("FAIL en_tc_ep0: got %b exp 1", tc); end
    et = 0; #1;
    tests++; if (tc !== 1'b0) begin fails++; $display("FAIL en_tc_et0: got %b exp 0", tc); end
    tick();
    tests++; if (q !== 4'd9) begin fails++; $display("FAIL en_hold_et: got %0d exp 9", q); end
    ep = 1;
    tick();
    tests++; if (q !== 4'd9 || wrap !== 1'b0) begin fails++; $display("FAIL en_hold_ep1: got q=%0d wrap=%b exp q=9 wrap=0", q, wrap); end
    ep = 0; ld_n = 0; d = 4'd4;
    tick();
    tests++; if (q !== 4'd4) begin fails++; $display("FAIL en_load: got %0d exp 4", q); end
    ld_n = 1;
  endtask

  task automatic test_back_to_back();
    ld_n = 0; d = 4'd9;
    tick();
    ld_n = 1; ep = 1; et = 1; ud = 1;
    tick();
    tests++; if (q !== 4'd0 || wrap !== 1'b1) begin fails++; $display("FAIL b2b_wrap: got q=%0d wrap=%b exp q=0 wrap=1", q, wrap); end
    ld_n = 0; d = 4'd7;
    tick();
    tests++; if (q !== 4'd7 || wrap !== 1'b0) begin fails++; $display("FAIL b2b_load: got q=%0d wrap=%b exp q=7 wrap=0", q, wrap); end
    ld_n = 1; ep = 0;
  endtask

  task automatic test_cascade();
    int hi_wraps;
    c_cr = 1;
    tick();
    c_cr = 0;
    hi_wraps = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hi_wrap === 1'b1) hi_wraps++;
      if (i == 44) begin
        tests++; if (hi_q !== 4'd4 || lo_q !== 4'd5) begin fails++; $display("FAIL casc_45: got %0d%0d exp 45", hi_q, lo_q); end
      end
    end
    tests++; if (hi_q !== 4'd0 || lo_q !== 4'd0) begin fails++; $display("FAIL casc_100: got %0d%0d exp 00", hi_q, lo_q); end
    tests++; if (hi_wraps !== 1) begin fails++; $display("FAIL casc_hiwrap: got %0d exp 1", hi_wraps); end
  endtask

  task automatic test_mod16();
    m_cr = 1; m_ld_n = 1; m_en = 0; m_d = 4'd0;
    tick();
    m_cr = 0; m_en = 1;
    repeat (15) tick();
    tests++; if (m_q !== 4'd15 || m_tc !== 1'b1) begin fails++; $display("FAIL m16_15: got q=%0d tc=%b exp q=15 tc=1", m_q, m_tc); end
    tick();
    tests++; if (m_q !== 4'd0 || m_wrap !== 1'b1) begin fails++; $display("FAIL m16_wrap: got q=%0d wrap=%b exp q=0 wrap=1", m_q, m_wrap); end
    m_ld_n = 0; m_d = 4'd15;
    tick();
    tests++; if (m_q !== 4'd15 || m_err !== 1'b0) begin fails++; $display("FAIL m16_ld15: got q=%0d err=%b exp q=15 err=0", m_q, m_err); end
    m_ld_n = 1;
  endtask

  initial begin
    cr = 1; ld_n = 1; ep = 0; et = 0; ud = 1; d = 4'd0;
    c_cr = 1; m_cr = 1; m_ld_n = 1; m_en = 0; m_d = 4'd0;
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_range();
    test_enables();
    test_back_to_back();
    test_cascade();
    test_mod16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
